// File: rtl/div_clk_mc.sv
// Multi-channel clock divider: per-channel square wave with 50 % or programmable duty plus a period-start tick.
// Latency: one cycle from sampling edge of i_en / i_load to outputs; configs apply at period boundaries.
// Backpressure: none; i_load always captures into the pending registers, and a later load overwrites an unapplied one.
//
// Ports:
//   clk, rstn        rising-edge clock, asynchronous active-low reset
//   i_en[N_CH]       per-channel run enable
//   i_period, i_high packed per channel at [k*CNT_W +: CNT_W], in clk cycles
//   i_mode[N_CH]     0 = half-period duty, 1 = duty from i_high
//   i_load           captures i_period/i_high/i_mode of all channels into the pending registers
//   o_div_clk        divided square wave (registered)
//   o_tick           one-cycle pulse in the first cycle of each period (registered)
//   o_pending        a captured config waits for its period boundary
//   o_cfg_err        channel is enabled but its active period is below 2
module div_clk_mc #(
   parameter int CNT_W = 28,
   parameter int N_CH  = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [N_CH-1:0]        i_en,
   input  logic [N_CH*CNT_W-1:0]  i_period,
   input  logic [N_CH*CNT_W-1:0]  i_high,
   input  logic [N_CH-1:0]        i_mode,
   input  logic                   i_load,
   output logic [N_CH-1:0]        o_div_clk,
   output logic [N_CH-1:0]        o_tick,
   output logic [N_CH-1:0]        o_pending,
   output logic [N_CH-1:0]        o_cfg_err
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // High time clipped to the period; mode 0 gives floor(period/2).
   function automatic logic [CNT_W-1:0] high_eff(input logic [CNT_W-1:0] per,
                                                 input logic [CNT_W-1:0] high,
                                                 input logic             mode);
      logic [CNT_W-1:0] h;
      h = mode ? high : (per >> 1);
      if (h > per) h = per;
      return h;
   endfunction

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] per_a_q, per_a_d;
      logic [CNT_W-1:0] high_a_q, high_a_d;
      logic             mode_a_q, mode_a_d;
      logic [CNT_W-1:0] pend_per_q, pend_per_d;
      logic [CNT_W-1:0] pend_high_q, pend_high_d;
      logic             pend_mode_q, pend_mode_d;
      logic             pend_vld_q, pend_vld_d;
      logic             en_q, en_d;
      logic             div_q, div_d;
      logic             tick_q, tick_d;
      logic             err_q, err_d;

      logic             run;
      logic             wrap;
      logic             apply;

      // run: the current cycle belongs to a live period, so cnt_q is meaningful.
      // en_q is needed so that an enable rise restarts at cnt=0 instead of counting on.
      assign run   = en_q && (per_a_q[CNT_W-1:1] != '0);
      assign wrap  = (cnt_q == per_a_q - ONE);
      // Not running: apply at once. Running: only at the last cycle of the period.
      assign apply = pend_vld_q && (!run || wrap);

      always_comb begin
         logic             act_ok;
         logic [CNT_W-1:0] hi;
         per_a_d     = per_a_q;
         high_a_d    = high_a_q;
         mode_a_d    = mode_a_q;
         pend_per_d  = pend_per_q;
         pend_high_d = pend_high_q;
         pend_mode_d = pend_mode_q;
         pend_vld_d  = pend_vld_q;
         en_d        = i_en[g];
         cnt_d       = '0;
         act_ok      = 1'b0;
         hi          = '0;

         if (apply) begin
            per_a_d    = pend_per_q;
            high_a_d   = pend_high_q;
            mode_a_d   = pend_mode_q;
            pend_vld_d = 1'b0;
         end

         // A load on an apply edge refills the pending slot after it has been consumed.
         if (i_load) begin
            pend_per_d  = i_period[g*CNT_W +: CNT_W];
            pend_high_d = i_high[g*CNT_W +: CNT_W];
            pend_mode_d = i_mode[g];
            pend_vld_d  = 1'b1;
         end

         if (i_en[g] && run && !wrap) cnt_d = cnt_q + ONE;

         // Outputs reflect the state being entered so they can be registered directly.
         act_ok = (per_a_d[CNT_W-1:1] != '0);
         hi     = high_eff(per_a_d, high_a_d, mode_a_d);
         div_d  = i_en[g] && act_ok && (cnt_d < hi);
         tick_d = i_en[g] && act_ok && (cnt_d == '0);
         err_d  = i_en[g] && !act_ok;
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            cnt_q       <= '0;
            per_a_q     <= '0;
            high_a_q    <= '0;
            mode_a_q    <= 1'b0;
            pend_per_q  <= '0;
            pend_high_q <= '0;
            pend_mode_q <= 1'b0;
            pend_vld_q  <= 1'b0;
            en_q        <= 1'b0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
         end else begin
            cnt_q       <= cnt_d;
            per_a_q     <= per_a_d;
            high_a_q    <= high_a_d;
            mode_a_q    <= mode_a_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pend_mode_q <= pend_mode_d;
            pend_vld_q  <= pend_vld_d;
            en_q        <= en_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
         end
      end

      assign o_div_clk[g] = div_q;
      assign o_tick[g]    = tick_q;
      assign o_pending[g] = pend_vld_q;
      assign o_cfg_err[g] = err_q;
   end

endmodule

// File: tb/tb_div_clk_mc.sv
// Bench for div_clk_mc: directed period/duty/reload/reset scenarios with literal
// expected sequences, then randomized enables and loads checked every cycle
// against a per-channel behavioural model.
module tb_div_clk_mc;

   localparam int CNT_W = 28;
   localparam int N_CH  = 4;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [N_CH-1:0]       i_en;
   logic [N_CH*CNT_W-1:0] i_period;
   logic [N_CH*CNT_W-1:0] i_high;
   logic [N_CH-1:0]       i_mode;
   logic                  i_load;
   logic [N_CH-1:0]       o_div_clk;
   logic [N_CH-1:0]       o_tick;
   logic [N_CH-1:0]       o_pending;
   logic [N_CH-1:0]       o_cfg_err;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   div_clk_mc #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
      .clk(clk), .rstn(rstn), .i_en(i_en), .i_period(i_period), .i_high(i_high),
      .i_mode(i_mode), .i_load(i_load), .o_div_clk(o_div_clk), .o_tick(o_tick),
      .o_pending(o_pending), .o_cfg_err(o_cfg_err)
   );

   initial forever #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] per;
      logic [31:0] high;
      logic [31:0] pper;
      logic [31:0] phigh;
      logic [31:0] phase;   // position within the current period
      logic        mode;
      logic        pmode;
      logic        pv;      // pending config waiting
      logic        en;      // enable seen at the last edge
   } ch_t;

   ch_t m_st [N_CH];

   function automatic ch_t model_step(ch_t s, logic en, logic ld,
                                      logic [31:0] lp, logic [31:0] lh, logic lm);
      ch_t n;
      logic live, boundary;
      n = s;
      live     = s.en && (s.per >= 2);
      boundary = !live || (s.phase == s.per - 1);
      if (s.pv && boundary) begin
         n.per = s.pper; n.high = s.phigh; n.mode = s.pmode; n.pv = 1'b0;
      end
      if (ld) begin
         n.pper = lp; n.phigh = lh; n.pmode = lm; n.pv = 1'b1;
      end
      n.phase = (en && live && !boundary) ? s.phase + 1 : 32'd0;
      n.en    = en;
      return n;
   endfunction

   function automatic logic e_ok(ch_t s);
      return s.en && (s.per >= 2);
   endfunction

   function automatic logic e_div(ch_t s);
      logic [31:0] h;
      h = s.mode ? s.high : s.per / 2;
      if (h > s.per) h = s.per;
      return e_ok(s) && (s.phase < h);
   endfunction

   function automatic logic [N_CH-1:0] exp_vec(int sel);
      logic [N_CH-1:0] v;
      v = '0;
      for (int k = 0; k < N_CH; k++) begin
         case (sel)
            0:       v[k] = e_div(m_st[k]);
            1:       v[k] = e_ok(m_st[k]) && (m_st[k].phase == 0);
            2:       v[k] = m_st[k].pv;
            default: v[k] = m_st[k].en && !e_ok(m_st[k]);
         endcase
      end
      return v;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N_CH; k++) m_st[k] <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++)
            m_st[k] <= model_step(m_st[k], i_en[k], i_load,
                                  32'(i_period[k*CNT_W +: CNT_W]),
                                  32'(i_high[k*CNT_W +: CNT_W]), i_mode[k]);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && chk_on) begin
         chk("cyc_div",  32'(o_div_clk), 32'(exp_vec(0)));
         chk("cyc_tick", 32'(o_tick),    32'(exp_vec(1)));
         chk("cyc_pend", 32'(o_pending), 32'(exp_vec(2)));
         chk("cyc_err",  32'(o_cfg_err), 32'(exp_vec(3)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(int ch, int per, int hi, logic md);
      i_period[ch*CNT_W +: CNT_W] = CNT_W'(per);
      i_high[ch*CNT_W +: CNT_W]   = CNT_W'(hi);
      i_mode[ch]                  = md;
   endtask

   // Disable ch0, load the config, let it apply while idle, then enable.
   task automatic cfg_run(int per, int hi, logic md);
      i_en[0] = 1'b0;
      set_cfg(0, per, hi, md);
      i_load = 1'b1;
      step();
      i_load = 1'b0;
      step();
      step();
      i_en[0] = 1'b1;
   endtask

   // Sample ch0 for n cycles; the first sample MSB-first. Clears i_load after the first edge.
   task automatic run_seq(input int n, output logic [31:0] dv, output logic [31:0] tk,
                          output logic [31:0] pd, output logic [31:0] er,
                          output logic [31:0] mdv, output logic [31:0] mtk);
      dv = '0; tk = '0; pd = '0; er = '0; mdv = '0; mtk = '0;
      for (int i = 0; i < n; i++) begin
         step();
         i_load = 1'b0;
         dv  = {dv[30:0],  o_div_clk[0]};
         tk  = {tk[30:0],  o_tick[0]};
         pd  = {pd[30:0],  o_pending[0]};
         er  = {er[30:0],  o_cfg_err[0]};
         mdv = {mdv[30:0], e_div(m_st[0])};
         mtk = {mtk[30:0], e_ok(m_st[0]) && (m_st[0].phase == 0)};
      end
   endtask

   initial begin
      logic [31:0] dv, tk, pd, er, mdv, mtk;
      rstn = 1'b0; i_en = '0; i_load = 1'b0; i_period = '0; i_high = '0; i_mode = '0;
      #12;
      chk("rst_div",  32'(o_div_clk), 32'd0);
      chk("rst_tick", 32'(o_tick),    32'd0);
      chk("rst_pend", 32'(o_pending), 32'd0);
      chk("rst_err",  32'(o_cfg_err), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();
      chk_on = 1'b1;

      // period 4, half duty
      cfg_run(4, 0, 1'b0);
      run_seq(8, dv, tk, pd, er, mdv, mtk);
      chk("p4_div",  dv,  32'b11001100);
      chk("p4_tick", tk,  32'b10001000);
      chk("p4_mdiv", mdv, 32'b11001100);
      chk("p4_mtick", mtk, 32'b10001000);
      chk("p4_other", 32'({o_div_clk[3:1], o_tick[3:1]}), 32'd0);

      // odd period, half duty: floor(5/2) high
      cfg_run(5, 0, 1'b0);
      run_seq(10, dv, tk, pd, er, mdv, mtk);
      chk("p5m0_div",  dv, 32'b1100011000);
      chk("p5m0_tick", tk, 32'b1000010000);
      chk("p5m0_mdiv", mdv, 32'b1100011000);

      cfg_run(5, 4, 1'b1);
      run_seq(10, dv, tk, pd, er, mdv, mtk);
      chk("p5h4_div", dv, 32'b1111011110);

      cfg_run(5, 0, 1'b1);
      run_seq(10, dv, tk, pd, er, mdv, mtk);
      chk("p5h0_div",  dv, 32'b0000000000);
      chk("p5h0_tick", tk, 32'b1000010000);

      cfg_run(5, 9, 1'b1);
      run_seq(10, dv, tk, pd, er, mdv, mtk);
      chk("p5h9_div",  dv, 32'b1111111111);
      chk("p5h9_tick", tk, 32'b1000010000);
      chk("p5h9_mtick", mtk, 32'b1000010000);

      // invalid period, then recovery by load while enabled
      cfg_run(1, 0, 1'b0);
      run_seq(5, dv, tk, pd, er, mdv, mtk);
      chk("inv_err",  er, 32'b11111);
      chk("inv_tick", tk, 32'b00000);
      chk("inv_div",  dv, 32'b00000);
      set_cfg(0, 3, 0, 1'b0);
      i_load = 1'b1;
      run_seq(7, dv, tk, pd, er, mdv, mtk);
      chk("rec_tick", tk, 32'b0100100);
      chk("rec_err",  er, 32'b1000000);
      chk("rec_div",  dv, 32'b0100100);

      // reload mid-period: current 4-cycle period completes first
      cfg_run(4, 0, 1'b0);
      run_seq(2, dv, tk, pd, er, mdv, mtk);
      set_cfg(0, 10, 0, 1'b0);
      i_load = 1'b1;
      run_seq(14, dv, tk, pd, er, mdv, mtk);
      chk("rl_div",  dv, 32'b00111110000011);
      chk("rl_tick", tk, 32'b00100000000010);
      chk("rl_pend", pd, 32'b11000000000000);

      // two loads before the wrap: last one wins
      set_cfg(0, 6, 0, 1'b0);
      i_load = 1'b1;
      run_seq(1, dv, tk, pd, er, mdv, mtk);
      set_cfg(0, 3, 0, 1'b0);
      i_load = 1'b1;
      run_seq(1, dv, tk, pd, er, mdv, mtk);
      run_seq(10, dv, tk, pd, er, mdv, mtk);
      chk("dbl_tick", tk, 32'b0000001001);
      chk("dbl_div",  dv, 32'b1000001001);

      // load on the wrap edge with a config already pending
      cfg_run(4, 0, 1'b0);
      run_seq(1, dv, tk, pd, er, mdv, mtk);
      set_cfg(0, 6, 0, 1'b0);
      i_load = 1'b1;
      run_seq(3, dv, tk, pd, er, mdv, mtk);
      chk("sim_pend0", pd, 32'b111);
      set_cfg(0, 2, 0, 1'b0);
      i_load = 1'b1;
      run_seq(9, dv, tk, pd, er, mdv, mtk);
      chk("sim_pend", pd, 32'b111111000);
      chk("sim_tick", tk, 32'b100000101);

      // asynchronous reset mid-period with a pending config
      cfg_run(4, 0, 1'b0);
      run_seq(1, dv, tk, pd, er, mdv, mtk);
      set_cfg(0, 6, 0, 1'b0);
      i_load = 1'b1;
      run_seq(1, dv, tk, pd, er, mdv, mtk);
      chk("rmo_pend", 32'(o_pending[0]), 32'd1);
      #3 rstn = 1'b0;
      #1 chk("rmo_outs", 32'({o_div_clk, o_tick, o_pending, o_cfg_err}), 32'd0);
      #2 rstn = 1'b1;
      run_seq(4, dv, tk, pd, er, mdv, mtk);
      chk("rmo_err",  er, 32'b1111);
      chk("rmo_div",  dv, 32'b0000);
      chk("rmo_pend2", pd, 32'b0000);

      // randomized enables and loads on all channels
      for (int c = 0; c < 4000; c++) begin
         step();
         i_load = ($urandom_range(0, 9) == 0);
         if (i_load) begin
            for (int k = 0; k < N_CH; k++) begin
               if ($urandom_range(0, 40) == 0)
                  set_cfg(k, (1 << CNT_W) - 1, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
               else
                  set_cfg(k, int'($urandom_range(0, 11)), int'($urandom_range(0, 14)),
                          1'($urandom_range(0, 1)));
            end
         end
         for (int k = 0; k < N_CH; k++)
            if ($urandom_range(0, 29) == 0) i_en[k] = ~i_en[k];
      end

      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_clk_mc.md
# div_clk_mc

Parametrised multi-channel clock divider for the frequency-meter test-signal path, successor to the single-channel 100 MHz divider. Each of N_CH channels produces a divided square wave with selectable 50 % or programmable duty cycle, plus a one-cycle period-start strobe. New configurations are double-buffered and applied only at a period boundary, so the outputs never glitch. Period and high time are given directly in clk cycles, with no divider in the datapath. Everything runs on the rising edge of the single system clock.

## Interface
- CNT_W, 28: width of the period, high-time and counter fields.
- N_CH, 4: number of independent channels.

- clk  in  1  system clock, rising edge only.
- rstn  in  1  asynchronous active-low reset.
- i_en  in  N_CH  per-channel run enable.
- i_period  in  N_CH*CNT_W  period in clk cycles; channel k at [k*CNT_W +: CNT_W].
- i_high  in  N_CH*CNT_W  high time in clk cycles; same packing. Ignored in mode 0.
- i_mode  in  N_CH  duty mode: 0 = half period (high = period>>1), 1 = high time from i_high.
- i_load  in  1  single-cycle strobe that captures i_period, i_high and i_mode for all channels into the pending registers.
- o_div_clk  out  N_CH  divided square wave, registered.
- o_tick  out  N_CH  one-cycle pulse in the first cycle of every period, registered.
- o_pending  out  N_CH  1 while a captured configuration waits to be applied.
- o_cfg_err  out  N_CH  1 while the channel is enabled and its active period is less than 2.

## Operation
- **Per-channel registers**
  - Active config: period_a, high_a, mode_a.
  - Pending config with a valid flag (drives o_pending).
  - Counter cnt[CNT_W-1:0].
- **Effective high time:** high_eff = (mode_a ? high_a : period_a>>1), clipped to period_a.
  - Odd period in mode 0 gives floor(period/2) high, e.g. period 5 → 2 high, 3 low.
  - high_eff == period_a → constant 1 with ticks.
  - high_eff == 0 → constant 0 with ticks.
- **Running** (i_en=1, period_a≥2):
  - cnt counts 0..period_a-1 and wraps to 0.
  - o_div_clk=1 for the cycles with cnt<high_eff.
  - o_tick=1 in the cycle with cnt==0.
- **Idle** (i_en=0):
  - cnt=0, o_div_clk=0, o_tick=0, o_cfg_err=0.
- **Invalid** (i_en=1, period_a<2):
  - Same outputs as idle, but o_cfg_err=1.
- **Load:** i_load=1 writes the pending registers and sets the valid flag on every channel. A second load before apply overwrites the pending config (last wins).
- **Apply** (pending → active, valid flag cleared):
  - Running channel: at the wrap edge (cnt==period_a-1), so the new period starts cleanly at cnt=0.
  - Idle or invalid channel: on the first edge where the valid flag is set.
- **Load coincident with an apply edge:** the previously pending config is applied, and the new one is captured as pending. If nothing was pending, the new config waits for the next boundary.
- **Enable rise** (i_en 0→1 sampled at edge E): the first period starts at E, so cnt=0 and o_tick=1 in the following cycle.
- **Enable fall** at edge E: outputs are 0 in the following cycle and cnt is cleared. Any pending config is applied on the next edge under the idle rule.
- Channels are fully independent apart from the shared i_load.

## Timing
- **Reset (async assert):**
  - o_div_clk=0, o_tick=0, o_pending=0, o_cfg_err=0.
  - cnt=0, period_a=0, high_a=0, mode_a=0, pending flags cleared.
- **Reset release:** synchronous to clk at the next rising edge.
- **Latency:** one cycle from the sampling edge of i_en or i_load to the output effect.
  - Running apply takes effect in the cycle after the wrap edge.
  - o_pending rises in the cycle after i_load and falls in the cycle after the apply edge.
- **Output registering:** all outputs are flops with no combinational path from inputs.
- **Tick spacing:** o_tick pulses are exactly period_a cycles apart in steady state.
- **No truncated period:** a config change never shortens or stretches the period in progress.
- **Counter width:** the counter never exceeds period_a-1. A period of 2^CNT_W-1 is legal.

## Test plan
1. **Basic mode 0:** reset; load ch0 period=4 mode=0; i_en[0]=1 → o_div_clk[0] repeats 1,1,0,0; o_tick[0] high every 4th cycle, aligned with the first 1; other channels stay 0.
2. **Odd period and mode 1:**
   - period=5 mode 0 → 1,1,0,0,0.
   - period=5 mode 1 high=4 → 1,1,1,1,0.
   - high=0 → constant 0 with ticks every 5 cycles.
   - high=9 → constant 1 with ticks every 5 cycles.
3. **Reload mid-period:** running period=4; at cnt=1 load period=10 → current period completes its 4 cycles; next tick starts 10-cycle periods (5 high); o_pending is high from the load+1 cycle until the cycle after the wrap. Also load twice before the wrap → only the second config appears.
4. **Invalid period:** i_en=1 with period=1 → o_cfg_err=1, no ticks, o_div_clk=0. Load period=3 → applied on the next edge, o_cfg_err drops, and ticks begin every 3 cycles.
5. **Simultaneous load and wrap:** load asserted on the wrap edge with a config already pending → the old pending config is applied and the new one remains pending (o_pending stays 1) until the next wrap.
6. **Reset mid-operation:** assert rstn=0 mid-period with a pending config → all outputs drop to 0 immediately (asynchronously); after release with i_en=1, the channel stays invalid (o_cfg_err=1) until a load.
